// File: rtl/drive_arbiter_if.sv
// Drive-command channel between the arbiter and the motor driver.
interface drive_arbiter_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_dir;
  logic [3:0] cmd_speed;

  modport master (output cmd_valid, cmd_dir, cmd_speed, input cmd_ready);
  modport slave  (input cmd_valid, cmd_dir, cmd_speed, output cmd_ready);
endinterface

// File: rtl/drive_arbiter.sv
// Drive-command arbiter: IR manual / vision auto / estop mode FSM feeding a valid/ready channel.
// Optional MIC_SPEED_EN: AUTO_TRACK speed follows mic_level instead of TRACK_SPEED.
module drive_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000,
  parameter int unsigned LOST_FRAMES    = 8,
  parameter int unsigned ACQ_FRAMES     = 3,
  parameter logic [3:0]  MANUAL_SPEED   = 4'd8,
  parameter logic [3:0]  SEARCH_SPEED   = 4'd4,
  parameter logic [3:0]  TRACK_SPEED    = 4'd10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            ir_cmd,
  input  logic                  ir_toggle,
  input  logic [3:0]            mic_level,
  input  logic                  vis_valid,
  input  logic [1:0]            vis_dir,
  input  logic                  frame_tick,
  output logic [2:0]            mode,
  drive_arbiter_if.master       cmd
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MANUAL = 3'd1,
    S_SEARCH = 3'd2,
    S_TRACK  = 3'd3,
    S_ESTOP  = 3'd4
  } state_t;

  localparam logic [2:0] D_STOP  = 3'd0;
  localparam logic [2:0] D_FWD   = 3'd1;
  localparam logic [2:0] D_LEFT  = 3'd3;
  localparam logic [2:0] D_RIGHT = 3'd4;

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned FMAX = (LOST_FRAMES > ACQ_FRAMES) ? LOST_FRAMES : ACQ_FRAMES;
  localparam int unsigned FW = $clog2(FMAX + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] ACQ_LAST = FW'(ACQ_FRAMES - 1);
  localparam logic [FW-1:0] LOST_LAST = FW'(LOST_FRAMES - 1);
  localparam logic [FW-1:0] ACQ_SAT = FW'(ACQ_FRAMES);
  localparam logic [FW-1:0] LOST_SAT = FW'(LOST_FRAMES);

  state_t        state, state_n;
  logic          toggle_q;
  logic [2:0]    man_dir, man_dir_n;
  logic [TW-1:0] tmo_cnt;
  logic [FW-1:0] acq_cnt, lost_cnt;
  logic [1:0]    vdir_q;
  logic [2:0]    last_dir, want_dir, ref_dir, out_dir;
  logic [3:0]    last_spd, want_spd, ref_spd, out_spd, trk_spd;
  logic          out_vld, hs;
  logic          ir_event, target, auto_entry;

  assign ir_event   = ir_toggle ^ toggle_q;
  assign target     = vis_valid && (vis_dir != 2'b11);
  assign auto_entry = (state_n == S_SEARCH || state_n == S_TRACK) && (state_n != state);
  assign mode       = state;

  // IR events take precedence; vision and timeout only act on quiet cycles.
  always_comb begin
    state_n   = state;
    man_dir_n = man_dir;
    if (ir_event) begin
      if (ir_cmd == 3'd7) begin
        state_n = S_ESTOP;
      end else begin
        case (state)
          S_IDLE: begin
            if (ir_cmd inside {[3'd1:3'd4]}) begin
              state_n = S_MANUAL; man_dir_n = ir_cmd;
            end else if (ir_cmd == 3'd5) begin
              state_n = S_SEARCH;
            end else if (ir_cmd == 3'd6) begin
              state_n = S_MANUAL; man_dir_n = D_STOP;
            end
          end
          S_MANUAL: begin
            if (ir_cmd <= 3'd4) man_dir_n = ir_cmd;
            else if (ir_cmd == 3'd5) state_n = S_SEARCH;
          end
          S_SEARCH, S_TRACK: begin
            if (ir_cmd == 3'd0) begin
              state_n = S_IDLE;
            end else if (ir_cmd <= 3'd4) begin
              state_n = S_MANUAL; man_dir_n = ir_cmd;
            end else if (ir_cmd == 3'd6) begin
              state_n = S_MANUAL; man_dir_n = D_STOP;
            end
          end
          S_ESTOP: if (ir_cmd == 3'd0) state_n = S_IDLE;
          default: state_n = S_IDLE;
        endcase
      end
    end else begin
      if (state == S_MANUAL && tmo_cnt == TMO_LAST) man_dir_n = D_STOP;
      if (frame_tick) begin
        if (state == S_SEARCH && target && acq_cnt == ACQ_LAST) state_n = S_TRACK;
        if (state == S_TRACK && !target && lost_cnt == LOST_LAST) state_n = S_SEARCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      toggle_q <= 1'b0;
      man_dir  <= D_STOP;
      tmo_cnt  <= '0;
      acq_cnt  <= '0;
      lost_cnt <= '0;
      vdir_q   <= 2'b00;
    end else begin
      state    <= state_n;
      toggle_q <= ir_toggle;
      man_dir  <= man_dir_n;
      if (ir_event) tmo_cnt <= '0;
      else if (state == S_MANUAL && tmo_cnt != TMO_LAST) tmo_cnt <= tmo_cnt + 1'b1;
      if (auto_entry) begin
        acq_cnt  <= '0;
        lost_cnt <= '0;
      end else if (frame_tick) begin
        if (target) begin
          acq_cnt  <= (acq_cnt == ACQ_SAT) ? acq_cnt : acq_cnt + 1'b1;
          lost_cnt <= '0;
        end else begin
          lost_cnt <= (lost_cnt == LOST_SAT) ? lost_cnt : lost_cnt + 1'b1;
          acq_cnt  <= '0;
        end
      end
      if (frame_tick && target) vdir_q <= vis_dir;
    end
  end

`ifdef MIC_SPEED_EN
  assign trk_spd = mic_level;
`else
  logic unused_mic;
  assign unused_mic = ^mic_level;
  assign trk_spd = TRACK_SPEED;
`endif

  always_comb begin
    want_dir = D_STOP;
    want_spd = 4'd0;
    case (state)
      S_MANUAL: if (man_dir != D_STOP) begin
        want_dir = man_dir; want_spd = MANUAL_SPEED;
      end
      S_SEARCH: begin
        want_dir = D_LEFT; want_spd = SEARCH_SPEED;
      end
      S_TRACK: if (trk_spd != 4'd0) begin
        want_spd = trk_spd;
        case (vdir_q)
          2'b00:   want_dir = D_FWD;
          2'b01:   want_dir = D_LEFT;
          2'b10:   want_dir = D_RIGHT;
          default: begin want_dir = D_STOP; want_spd = 4'd0; end
        endcase
      end
      default: ;
    endcase
  end

  // Compare against the word leaving this cycle, else the last word delivered.
  assign hs      = out_vld && cmd.cmd_ready;
  assign ref_dir = hs ? out_dir : last_dir;
  assign ref_spd = hs ? out_spd : last_spd;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld  <= 1'b0;
      out_dir  <= D_STOP;
      out_spd  <= 4'd0;
      last_dir <= D_STOP;
      last_spd <= 4'd0;
    end else begin
      if (hs) begin
        last_dir <= out_dir;
        last_spd <= out_spd;
      end
      if (!out_vld || cmd.cmd_ready) begin
        if (want_dir != ref_dir || want_spd != ref_spd) begin
          out_vld <= 1'b1;
          out_dir <= want_dir;
          out_spd <= want_spd;
        end else begin
          out_vld <= 1'b0;
        end
      end
    end
  end

  assign cmd.cmd_valid = out_vld;
  assign cmd.cmd_dir   = out_dir;
  assign cmd.cmd_speed = out_spd;

endmodule

// File: tb/tb_drive_arbiter.sv
// Scoreboard bench for drive_arbiter: directed IR/vision stimulus, monitor checks every accepted command.
module tb_drive_arbiter;
  logic       clk, reset;
  logic [2:0] ir_cmd;
  logic       ir_toggle;
  logic [3:0] mic_level;
  logic       vis_valid;
  logic [1:0] vis_dir;
  logic       frame_tick;
  logic [2:0] mode;

  drive_arbiter_if cmd_bus();

  drive_arbiter #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .ir_cmd(ir_cmd), .ir_toggle(ir_toggle),
    .mic_level(mic_level), .vis_valid(vis_valid), .vis_dir(vis_dir),
    .frame_tick(frame_tick), .mode(mode), .cmd(cmd_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] exq[$];
  int n_chk = 0, n_fail = 0, m_chk = 0, m_fail = 0;

`ifdef MIC_SPEED_EN
  localparam logic [3:0] TRK7  = 4'd7;
  localparam logic [3:0] TRK12 = 4'd12;
`else
  localparam logic [3:0] TRK7  = 4'd10;
  localparam logic [3:0] TRK12 = 4'd10;
`endif

  // Every accepted word must be the next one the stimulus expected.
  always @(negedge clk) begin
    if (!reset && cmd_bus.cmd_valid && cmd_bus.cmd_ready) begin
      m_chk++;
      if (exq.size() == 0) begin
        m_fail++;
        $display("FAIL unexpected_cmd: got dir %0d speed %0d, none expected",
                 cmd_bus.cmd_dir, cmd_bus.cmd_speed);
      end else begin
        logic [6:0] e;
        e = exq.pop_front();
        if ({cmd_bus.cmd_dir, cmd_bus.cmd_speed} !== e)
          begin
            m_fail++;
            $display("FAIL cmd_word: got dir %0d speed %0d, expected dir %0d speed %0d",
                     cmd_bus.cmd_dir, cmd_bus.cmd_speed, e[6:4], e[3:0]);
          end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ir(input logic [2:0] c);
    ir_cmd = c;
    ir_toggle = ~ir_toggle;
    step(1);
  endtask

  task automatic tick(input logic v, input logic [1:0] d);
    frame_tick = 1'b1; vis_valid = v; vis_dir = d;
    step(1);
    frame_tick = 1'b0; vis_valid = 1'b0;
  endtask

  task automatic push(input logic [2:0] d, input logic [3:0] s);
    exq.push_back({d, s});
  endtask

  initial begin
    reset = 1'b1; ir_cmd = 3'd0; ir_toggle = 1'b0; mic_level = 4'd7;
    vis_valid = 1'b0; vis_dir = 2'b00; frame_tick = 1'b0; cmd_bus.cmd_ready = 1'b1;
    step(3);
    chk("reset_mode", 8'(mode), 8'd0);
    chk("reset_valid", 8'(cmd_bus.cmd_valid), 8'd0);
    chk("reset_dir", 8'(cmd_bus.cmd_dir), 8'd0);
    chk("reset_speed", 8'(cmd_bus.cmd_speed), 8'd0);
    reset = 1'b0;
    step(1);

    // Manual FWD, then inactivity timeout to STOP
    push(3'd1, 4'd8);
    ir(3'd1);
    chk("manual_mode", 8'(mode), 8'd1);
    chk("ir_latency_valid_low", 8'(cmd_bus.cmd_valid), 8'd0);
    step(1);
    chk("ir_latency_valid_high", 8'(cmd_bus.cmd_valid), 8'd1);
    push(3'd0, 4'd0);
    step(99);
    chk("timeout_not_yet", 8'(cmd_bus.cmd_valid), 8'd0);
    step(1);
    chk("timeout_edge_valid", 8'(cmd_bus.cmd_valid), 8'd1);
    chk("timeout_dir", 8'(cmd_bus.cmd_dir), 8'd0);
    chk("timeout_mode", 8'(mode), 8'd1);
    step(2);

    // Acquire, track, lose
    push(3'd3, 4'd4);
    ir(3'd5);
    chk("search_mode", 8'(mode), 8'd2);
    step(2);
    push(3'd3, TRK7);
    tick(1'b1, 2'b01); tick(1'b1, 2'b01);
    chk("acq_two_ticks", 8'(mode), 8'd2);
    tick(1'b1, 2'b01);
    chk("acq_third_tick", 8'(mode), 8'd3);
    step(2);
    push(3'd3, 4'd4);
    repeat (7) tick(1'b0, 2'b00);
    chk("lost_seven", 8'(mode), 8'd3);
    tick(1'b0, 2'b00);
    chk("lost_eight", 8'(mode), 8'd2);
    step(2);

    // Backpressure: FWD held, intermediate LEFT dropped
    cmd_bus.cmd_ready = 1'b0;
    push(3'd1, 4'd8);
    ir(3'd1);
    step(1);
    ir(3'd3);
    ir(3'd4);
    step(2);
    chk("bp_valid", 8'(cmd_bus.cmd_valid), 8'd1);
    chk("bp_dir", 8'(cmd_bus.cmd_dir), 8'd1);
    chk("bp_speed", 8'(cmd_bus.cmd_speed), 8'd8);
    push(3'd4, 4'd8);
    cmd_bus.cmd_ready = 1'b1;
    step(3);
    chk("bp_drained", 8'(cmd_bus.cmd_valid), 8'd0);

    // Track centre with mic speed, then ESTOP latching
    push(3'd3, 4'd4);
    ir(3'd5);
    step(2);
    mic_level = 4'd12;
    push(3'd1, TRK12);
    repeat (3) tick(1'b1, 2'b00);
    chk("track_centre_mode", 8'(mode), 8'd3);
    step(2);
    mic_level = 4'd0;
`ifdef MIC_SPEED_EN
    push(3'd0, 4'd0);
`endif
    step(2);
    mic_level = 4'd12;
`ifdef MIC_SPEED_EN
    push(3'd1, 4'd12);
`endif
    step(2);
    push(3'd0, 4'd0);
    ir(3'd7);
    chk("estop_mode", 8'(mode), 8'd4);
    step(2);
    ir(3'd1);
    chk("estop_ignore_fwd", 8'(mode), 8'd4);
    ir(3'd5);
    chk("estop_ignore_auto", 8'(mode), 8'd4);
    ir(3'd0);
    chk("estop_release", 8'(mode), 8'd0);
    step(3);
    chk("estop_no_cmd", 8'(cmd_bus.cmd_valid), 8'd0);

    // IR MANUAL in the same cycle as the third acquiring tick
    push(3'd3, 4'd4);
    ir(3'd5);
    step(2);
    tick(1'b1, 2'b01); tick(1'b1, 2'b01);
    push(3'd0, 4'd0);
    frame_tick = 1'b1; vis_valid = 1'b1; vis_dir = 2'b01;
    ir_cmd = 3'd6; ir_toggle = ~ir_toggle;
    step(1);
    frame_tick = 1'b0; vis_valid = 1'b0;
    chk("simul_mode", 8'(mode), 8'd1);
    step(3);
    chk("simul_mode_hold", 8'(mode), 8'd1);

    chk("queue_drained", 8'(exq.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk + m_chk, n_fail + m_fail);
    $finish;
  end
endmodule

// File: doc/drive_arbiter.md
# drive_arbiter

Arbitrates the robot's single drive-command channel between the IR remote (`state_control`/`toggle`), the vision classifier (`orangeDetected`/`direction`) and the microphone level (`mapped_value`). A mode FSM selects IR manual control, autonomous search/track, or emergency stop. It issues direction and speed commands over a valid/ready handshake to the downstream motor driver. It sits in the top level beside `classification` and `IR_top_level`, clocked by the 25 MHz VGA clock.

## Interface
- `TIMEOUT_CYCLES`, 25_000_000: manual-mode inactivity timeout, in clk cycles (1 s).
- `LOST_FRAMES`, 8: consecutive frames without a target before leaving AUTO_TRACK.
- `ACQ_FRAMES`, 3: consecutive frames with a target before entering AUTO_TRACK.
- `MANUAL_SPEED`, 4'd8: speed used for IR manual moves.
- `SEARCH_SPEED`, 4'd4: rotate speed in AUTO_SEARCH.
- `TRACK_SPEED`, 4'd10: track speed when `MIC_SPEED_EN` is undefined.
- `clk` in 1: sole clock. All inputs are synchronous to it.
- `reset` in 1: synchronous, active-high.
- `ir_cmd` in 3: IR command code. 0 STOP/IDLE, 1 FWD, 2 BACK, 3 LEFT, 4 RIGHT, 5 AUTO, 6 MANUAL, 7 ESTOP.
- `ir_toggle` in 1: level that flips once per new IR frame. Any change is one IR event.
- `mic_level` in 4: microphone loudness, 0–15.
- `vis_valid` in 1: target detected this frame.
- `vis_dir` in 2: target position. 00 centre, 01 left, 10 right, 11 invalid.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `cmd_ready` in 1: motor driver accepts the command.
- `cmd_valid` out 1: command pending.
- `cmd_dir` out 3: 0 STOP, 1 FWD, 2 BACK, 3 LEFT, 4 RIGHT.
- `cmd_speed` out 4: speed, 0–15.
- `mode` out 3: 0 IDLE, 1 MANUAL, 2 AUTO_SEARCH, 3 AUTO_TRACK, 4 ESTOP.

## Operation
- **IR event detection.** `ir_event = ir_toggle ^ toggle_q`. `toggle_q` is registered every cycle.
- **Event priority.** `ir_cmd` is evaluated only on an IR event. ESTOP (7) takes priority from every state.

**State transitions on IR events:**
- **IDLE**
  - 1–4 → MANUAL, direction latched.
  - 5 → AUTO_SEARCH.
  - 6 → MANUAL with STOP.
- **MANUAL**
  - 1–4 latch a direction.
  - 0 latches STOP.
  - 5 → AUTO_SEARCH.
  - 6 is ignored.
- **AUTO_SEARCH / AUTO_TRACK**
  - 0 → IDLE.
  - 1–4 → MANUAL, direction latched.
  - 6 → MANUAL with STOP.
  - 5 is ignored.
- **ESTOP**
  - Only 0 → IDLE.
  - All other codes are ignored.

**Desired command per state:**
- IDLE and ESTOP: STOP/0.
- MANUAL: latched direction at `MANUAL_SPEED`. STOP/0 when the latched direction is STOP.
- AUTO_SEARCH: LEFT at `SEARCH_SPEED`.
- AUTO_TRACK: direction from the last sampled `vis_dir` (centre→FWD, left→LEFT, right→RIGHT) at track speed.
  - Track speed is 0 → STOP/0.

**Manual timeout.**
- A counter clears on every IR event and on entering MANUAL.
- When it reaches `TIMEOUT_CYCLES`-1, the latched direction becomes STOP. The state stays MANUAL.
- The counter saturates until the next IR event.

**Vision counters.**
- Updated only on `frame_tick`. A target is present when `vis_valid && vis_dir != 11`.
- `acq_cnt` increments on a tick with a target and clears on a tick without one.
- `lost_cnt` increments on a tick without a target and clears on a tick with one.
- Both clear on entry to any AUTO state.
- AUTO_SEARCH → AUTO_TRACK on the tick at which `acq_cnt` reaches `ACQ_FRAMES`.
- AUTO_TRACK → AUTO_SEARCH on the tick at which `lost_cnt` reaches `LOST_FRAMES`.
- `vis_dir` is registered on ticks with a target.

**Simultaneous events.**
- An IR event wins over a vision transition in the same cycle.
- Counters still clear on the resulting AUTO entry.

**Handshake.**
- `last_sent` resets to STOP/0 and updates on every `cmd_valid && cmd_ready`.
- When `!cmd_valid`, or during a handshake cycle, the desired command is compared with `last_sent` (or with the word being accepted).
  - If it differs, it is loaded into `cmd_dir`/`cmd_speed` and `cmd_valid` is asserted.
  - Otherwise `cmd_valid` is deasserted.
- While `cmd_valid && !cmd_ready`, the payload is held stable. This applies even on ESTOP.
- Intermediate desired values are dropped. Only the value current at the next load is sent.

## Timing
- **Reset values:** `mode`=0, `cmd_valid`=0, `cmd_dir`=0, `cmd_speed`=0. All counters, `toggle_q` and `last_sent` clear.
- **Reset mid-handshake:** a pending command is discarded.
- **IR latency:** `ir_toggle` flips before edge N. `mode` updates after edge N. `cmd_valid` rises after edge N+1 when the channel is free.
- **Vision latency:** `mode` updates after the edge sampling the qualifying `frame_tick`. `cmd_valid` follows one edge later.
- **Timeout:** STOP is latched after edge `TIMEOUT_CYCLES` counted from the edge of the last IR event.
- **Throughput:** one command per cycle with `cmd_ready` held high.

## Configuration
- **`MIC_SPEED_EN` defined:** AUTO_TRACK speed = `mic_level`. A level of 0 yields STOP/0.
- **`MIC_SPEED_EN` undefined:** AUTO_TRACK speed = `TRACK_SPEED`. `mic_level` is unused.

## Test plan
- **IR manual move then timeout.** Reset, `cmd_ready`=1, flip `ir_toggle` with `ir_cmd`=1 → `mode`=1. One cycle later `cmd_valid`=1, `cmd_dir`=1, `cmd_speed`=8. After `TIMEOUT_CYCLES` (test override 100) with no IR event → single command `cmd_dir`=0, `cmd_speed`=0.
- **Acquire, track, lose.** IR 5 → `mode`=2, command LEFT/4. Three ticks with `vis_valid`=1, `vis_dir`=01 → `mode`=3, command LEFT at track speed. Eight ticks with `vis_valid`=0 → `mode`=2, LEFT/4.
- **Backpressure.** Hold `cmd_ready`=0 after FWD/8 is asserted, then issue IR 3 then IR 4 → payload stays FWD/8. Raise `cmd_ready` → next word RIGHT/8; LEFT is never sent.
- **ESTOP latching.** IR 7 while in AUTO_TRACK → `mode`=4, STOP/0. IR 1 and IR 5 → `mode` stays 4. IR 0 → `mode`=0, no new command (`last_sent` already STOP).
- **Simultaneous IR event and 3rd acquiring tick.** Same cycle, `ir_cmd`=6 → `mode`=1 (MANUAL), never 3.
- **Mic speed.** With `MIC_SPEED_EN` in AUTO_TRACK centre: `mic_level` 12→0 → FWD/12 then STOP/0. Without the macro → FWD/10 regardless of `mic_level`.
